// File: rtl/reg_wordline_decode_4_16_pkg.sv
// rtl/reg_wordline_decode_4_16_pkg.sv - shared constants and types for the regfile wordline decode
// Purpose: register ID width, wordline count and the one-hot wordline type
//          used by the decoders and the top-level state registers.
package reg_wordline_decode_4_16_pkg;

    localparam int ID_W    = 4;
    localparam int NUM_REG = 16;   // must equal 2**ID_W; other sizes are not supported

    typedef logic [NUM_REG-1:0] wordline_t;
    typedef logic [ID_W-1:0]    reg_id_t;

endpackage

// File: rtl/reg_wordline_decode_4_16_read_decoder.sv
// rtl/reg_wordline_decode_4_16_read_decoder.sv - unconditional 4-to-16 one-hot decoder
// Purpose: RegId -> one-hot Wordline, purely combinational.
// Ports:
//   RegId    in  4   register ID
//   Wordline out 16  one-hot select (bit RegId set)
module ReadDecoder_4_16
    import reg_wordline_decode_4_16_pkg::*;
(
    input  logic [ID_W-1:0]    RegId,
    output logic [NUM_REG-1:0] Wordline
);

    // A shift rather than a case statement so that an X/Z on RegId shows up
    // as X on the wordline instead of being silently masked.
    assign Wordline = wordline_t'(1) << RegId;

endmodule

// File: rtl/reg_wordline_decode_4_16_write_decoder.sv
// rtl/reg_wordline_decode_4_16_write_decoder.sv - enable-gated 4-to-16 one-hot decoder
// Purpose: RegId -> one-hot Wordline when WriteReg is high, all-zero otherwise.
// Ports:
//   RegId    in  4   register ID
//   WriteReg in  1   write enable
//   Wordline out 16  one-hot select or all-zero
module WriteDecoder_4_16
    import reg_wordline_decode_4_16_pkg::*;
(
    input  logic [ID_W-1:0]    RegId,
    input  logic               WriteReg,
    output logic [NUM_REG-1:0] Wordline
);

    wordline_t raw_wordline;

    ReadDecoder_4_16 u_decode (
        .RegId    (RegId),
        .Wordline (raw_wordline)
    );

    assign Wordline = raw_wordline & {NUM_REG{WriteReg}};

endmodule

// File: rtl/reg_wordline_decode_4_16.sv
// rtl/reg_wordline_decode_4_16.sv - regfile read/write wordline decode with last-write record
// Purpose: combinational read and write wordline decode for a 16x16 regfile,
//          plus a registered copy of the most recent committed write wordline.
// Ports:
//   clk            in  1   clock, rising edge
//   rst_n          in  1   asynchronous active-low reset
//   RdRegId        in  4   register ID to read
//   WrRegId        in  4   register ID to write
//   WriteReg       in  1   write enable
//   ReadWordline   out 16  one-hot read select (combinational)
//   WriteWordline  out 16  one-hot write select or zero (combinational)
//   LastWrWordline out 16  WriteWordline captured at the last write edge
//   WrValid        out 1   set once any write has been committed since reset
module reg_wordline_decode_4_16
    import reg_wordline_decode_4_16_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ID_W-1:0]    RdRegId,
    input  logic [ID_W-1:0]    WrRegId,
    input  logic               WriteReg,
    output logic [NUM_REG-1:0] ReadWordline,
    output logic [NUM_REG-1:0] WriteWordline,
    output logic [NUM_REG-1:0] LastWrWordline,
    output logic               WrValid
);

    wordline_t last_wr_wordline_q, last_wr_wordline_d;
    logic      wr_valid_q, wr_valid_d;

    // Decode paths never see clk/rst_n, so they stay live during reset.
    ReadDecoder_4_16 u_read_dec (
        .RegId    (RdRegId),
        .Wordline (ReadWordline)
    );

    WriteDecoder_4_16 u_write_dec (
        .RegId    (WrRegId),
        .WriteReg (WriteReg),
        .Wordline (WriteWordline)
    );

    always_comb begin
        last_wr_wordline_d = last_wr_wordline_q;
        wr_valid_d         = wr_valid_q;
        if (WriteReg) begin
            last_wr_wordline_d = WriteWordline;
            wr_valid_d         = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_wordline_q <= '0;
            wr_valid_q         <= 1'b0;
        end else begin
            last_wr_wordline_q <= last_wr_wordline_d;
            wr_valid_q         <= wr_valid_d;
        end
    end

    assign LastWrWordline = last_wr_wordline_q;
    assign WrValid        = wr_valid_q;

endmodule

// File: tb/tb_reg_wordline_decode_4_16.sv
// tb/tb_reg_wordline_decode_4_16.sv - self-checking bench for reg_wordline_decode_4_16
module tb_reg_wordline_decode_4_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  RdRegId;
    logic [3:0]  WrRegId;
    logic        WriteReg;
    logic [15:0] ReadWordline;
    logic [15:0] WriteWordline;
    logic [15:0] LastWrWordline;
    logic        WrValid;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] rd;
        logic [15:0] wr;
    } exp_t;

    exp_t sb_q[$];

    // Reference model of the two state registers.
    logic [15:0] m_last;
    logic        m_valid;

    always #5 clk = ~clk;

    reg_wordline_decode_4_16 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RdRegId        (RdRegId),
        .WrRegId        (WrRegId),
        .WriteReg       (WriteReg),
        .ReadWordline   (ReadWordline),
        .WriteWordline  (WriteWordline),
        .LastWrWordline (LastWrWordline),
        .WrValid        (WrValid)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last  <= 16'h0000;
            m_valid <= 1'b0;
        end else if (WriteReg) begin
            m_last  <= 16'h0001 << WrRegId;
            m_valid <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input logic [3:0] rd, input logic [3:0] wr, input logic we);
        exp_t e;
        e.rd = 16'h0001 << rd;
        e.wr = we ? (16'h0001 << wr) : 16'h0000;
        sb_q.push_back(e);
    endtask

    task automatic pop_and_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 16'h0001, 16'h0000);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_rd"}, ReadWordline, e.rd);
            check_eq({tag, "_wr"}, WriteWordline, e.wr);
        end
    endtask

    // Drive away from the rising edge, then check the combinational outputs
    // one time unit later with no clock edge in between.
    task automatic apply(input logic [3:0] rd, input logic [3:0] wr, input logic we, input string tag);
        @(negedge clk);
        RdRegId  = rd;
        WrRegId  = wr;
        WriteReg = we;
        push_expected(rd, wr, we);
        #1;
        pop_and_compare(tag);
        check_eq({tag, "_last"}, LastWrWordline, m_last);
        check_eq({tag, "_valid"}, {15'd0, WrValid}, {15'd0, m_valid});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        RdRegId  = 4'd0;
        WrRegId  = 4'd0;
        WriteReg = 1'b0;
        push_expected(4'd0, 4'd0, 1'b0);
        #2;
        pop_and_compare("reset");
        check_eq("reset_last", LastWrWordline, 16'h0000);
        check_eq("reset_valid", {15'd0, WrValid}, 16'h0000);

        @(negedge clk);
        rst_n = 1'b1;

        // Read/write to the same register, no bypass.
        apply(4'd3, 4'd3, 1'b1, "same_id_we1");
        check_eq("t1_rd_const", ReadWordline, 16'h0008);
        check_eq("t1_wr_const", WriteWordline, 16'h0008);

        apply(4'd5, 4'd5, 1'b0, "same_id_we0");
        check_eq("t2_wr_const", WriteWordline, 16'h0000);

        // Full sweep; read and write walk in opposite directions.
        for (int i = 0; i < 16; i++) begin
            apply(4'(i), 4'(15 - i), 1'b1, $sformatf("sweep%0d", i));
            check_eq($sformatf("sweep%0d_rd_ones", i), 16'($countones(ReadWordline)), 16'd1);
            check_eq($sformatf("sweep%0d_wr_ones", i), 16'($countones(WriteWordline)), 16'd1);
        end
        apply(4'd15, 4'd15, 1'b1, "id15");
        check_eq("id15_rd_const", ReadWordline, 16'h8000);
        check_eq("id15_wr_const", WriteWordline, 16'h8000);

        // A handful of random patterns.
        for (int i = 0; i < 8; i++) begin
            apply(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)),
                  $sformatf("rand%0d", i));
        end

        apply(4'd7, 4'd12, 1'b1, "indep");
        check_eq("indep_rd_const", ReadWordline, 16'h0080);
        check_eq("indep_wr_const", WriteWordline, 16'h1000);

        // Write commit then hold.
        @(negedge clk);
        WriteReg = 1'b1;
        WrRegId  = 4'd9;
        @(posedge clk);
        #1;
        check_eq("commit9_last", LastWrWordline, 16'h0200);
        check_eq("commit9_valid", {15'd0, WrValid}, 16'h0001);
        @(negedge clk);
        WriteReg = 1'b0;
        WrRegId  = 4'd2;
        @(posedge clk);
        #1;
        check_eq("hold_last", LastWrWordline, 16'h0200);
        check_eq("hold_valid", {15'd0, WrValid}, 16'h0001);

        // Asynchronous reset mid-cycle; decoders stay live.
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        RdRegId  = 4'd11;
        WrRegId  = 4'd14;
        WriteReg = 1'b1;
        push_expected(4'd11, 4'd14, 1'b1);
        #1;
        check_eq("async_rst_last", LastWrWordline, 16'h0000);
        check_eq("async_rst_valid", {15'd0, WrValid}, 16'h0000);
        pop_and_compare("in_reset");
        @(posedge clk);
        #1;
        check_eq("rst_edge_last", LastWrWordline, 16'h0000);
        check_eq("rst_edge_valid", {15'd0, WrValid}, 16'h0000);

        @(negedge clk);
        WriteReg = 1'b0;
        rst_n    = 1'b1;
        apply(4'd1, 4'd6, 1'b0, "post_rst_nowrite");
        apply(4'd0, 4'd0, 1'b0, "post_rst_hold");
        check_eq("post_rst_valid0", {15'd0, WrValid}, 16'h0000);
        apply(4'd2, 4'd0, 1'b1, "post_rst_w0");
        apply(4'd2, 4'd0, 1'b0, "post_rst_w0_seen");
        check_eq("post_rst_last_r0", LastWrWordline, 16'h0001);

        if (sb_q.size() != 0)
            check_eq("sb_leftover", 16'(sb_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
